// File: rtl/iomem_arb_pkg.sv
// -----------------------------------------------------------------------------
// iomem_arb_pkg
// Shared definitions for the picosoc iomem arbiter:
//   IOMEM_AW / IOMEM_DW / IOMEM_SW : address, data and strobe widths of the port
//   arb_state_t                    : arbiter FSM states (IDLE, BUSY)
//   TIMEOUT_RDATA                  : read data returned on a timed-out transaction
//   idx_width()                    : width of a requester index for n requesters
// -----------------------------------------------------------------------------
package iomem_arb_pkg;

    localparam int IOMEM_AW = 32;
    localparam int IOMEM_DW = 32;
    localparam int IOMEM_SW = 4;

    localparam logic [IOMEM_DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iomem_rr_picker.sv
// -----------------------------------------------------------------------------
// iomem_rr_picker
// Combinational rotate-priority encoder. Searches req starting at bit ptr and
// moving upward with wrap-around; reports the first set bit.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  GW    search start position (0..NREQ-1)
//   found out 1     at least one request bit is set
//   index out GW    index of the first set bit at or after ptr (0 when !found)
// -----------------------------------------------------------------------------
module iomem_rr_picker
    import iomem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic            found,
    output logic [GW-1:0]   index
);

    // One extra bit so ptr + k never overflows before the wrap correction.
    always_comb begin
        logic [GW:0] cand;
        cand  = '0;
        found = 1'b0;
        index = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NREQ)) begin
                cand = cand - (GW+1)'(NREQ);
            end
            if (!found && req[cand[GW-1:0]]) begin
                found = 1'b1;
                index = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
// Shares one picosoc iomem target port between NREQ masters. Round-robin,
// one transaction in flight; the granted master's slice is passed through
// combinationally to the target while BUSY, and one IDLE cycle separates
// consecutive transactions.
//
// Optional feature: define IOMEM_ARB_TIMEOUT_EN to enable a target-response
// timeout of TIMEOUT cycles. On expiry the arbiter completes the transaction
// itself with read data 32'hDEAD_BEEF and sets the sticky timeout_err.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   req_valid  [NREQ]        per-master request, held until its req_ready
//   req_addr   [NREQ*32]     per-master address, slice i = [32*i +: 32]
//   req_wdata  [NREQ*32]     per-master write data
//   req_wstrb  [NREQ*4]      per-master byte strobes, 0 = read
//   req_ready  [NREQ]        one-hot completion pulse to the granted master
//   req_rdata  [32]          read data, meaningful with a req_ready bit
//   t_valid/t_ready          target handshake
//   t_addr/t_wdata/t_wstrb   target request fields
//   t_rdata                  target read data
//   grant_id   [3]           current / last granted master
//   busy                     transaction in flight
//   timeout_err              sticky timeout flag (0 without the timeout feature)
// -----------------------------------------------------------------------------
module iomem_arbiter
    import iomem_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*IOMEM_AW-1:0] req_addr,
    input  logic [NREQ*IOMEM_DW-1:0] req_wdata,
    input  logic [NREQ*IOMEM_SW-1:0] req_wstrb,
    output logic [NREQ-1:0]          req_ready,
    output logic [IOMEM_DW-1:0]      req_rdata,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [IOMEM_AW-1:0]      t_addr,
    output logic [IOMEM_DW-1:0]      t_wdata,
    output logic [IOMEM_SW-1:0]      t_wstrb,
    input  logic [IOMEM_DW-1:0]      t_rdata,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int GW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("iomem_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
    end

    arb_state_t    state_reg, state_next;
    logic [GW-1:0] grant_reg, grant_next;
    logic [GW-1:0] ptr_reg, ptr_next;
    logic [GW-1:0] ptr_after_grant;
    logic          pick_found;
    logic [GW-1:0] pick_index;
    logic          timeout_hit;

    // Unpack the flat request buses into per-master arrays for muxing.
    logic [IOMEM_AW-1:0] addr_arr  [NREQ];
    logic [IOMEM_DW-1:0] wdata_arr [NREQ];
    logic [IOMEM_SW-1:0] wstrb_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[gi*IOMEM_AW +: IOMEM_AW];
        assign wdata_arr[gi] = req_wdata[gi*IOMEM_DW +: IOMEM_DW];
        assign wstrb_arr[gi] = req_wstrb[gi*IOMEM_SW +: IOMEM_SW];
    end

    iomem_rr_picker #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .found (pick_found),
        .index (pick_index)
    );

    // The master after the current one gets first look next time, so nobody
    // wins twice in a row while another is waiting.
    assign ptr_after_grant = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + GW'(1);
    assign grant_id        = 3'(grant_reg);

`ifdef IOMEM_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_reg;
    logic        timeout_err_reg;

    // Counts BUSY cycles without t_ready; held at 0 outside BUSY so it is
    // already clear on the first BUSY cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg != BUSY) begin
                to_cnt_reg <= '0;
            end else if (!t_ready) begin
                to_cnt_reg <= to_cnt_reg + 16'd1;
            end
            // A late t_ready in the expiry cycle is a normal completion.
            if (state_reg == BUSY && req_valid[grant_reg] && !t_ready && timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state_reg == BUSY) && (to_cnt_reg == 16'(TIMEOUT));
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        t_valid    = 1'b0;
        t_addr     = '0;
        t_wdata    = '0;
        t_wstrb    = '0;
        req_ready  = '0;
        req_rdata  = '0;
        busy       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_index;
                    state_next = BUSY;
                end
            end

            BUSY: begin
                busy      = 1'b1;
                t_valid   = req_valid[grant_reg];
                t_addr    = addr_arr[grant_reg];
                t_wdata   = wdata_arr[grant_reg];
                t_wstrb   = wstrb_arr[grant_reg];
                req_rdata = t_rdata;
                if (!t_valid) begin
                    // Master withdrew its request: abandon without a ready.
                    state_next = IDLE;
                    ptr_next   = ptr_after_grant;
                end else if (t_ready) begin
                    req_ready[grant_reg] = 1'b1;
                    state_next           = IDLE;
                    ptr_next             = ptr_after_grant;
                end else if (timeout_hit) begin
                    req_ready[grant_reg] = 1'b1;
                    req_rdata            = TIMEOUT_RDATA;
                    state_next           = IDLE;
                    ptr_next             = ptr_after_grant;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iomem_arbiter
// Directed bench for iomem_arbiter (NREQ=2, TIMEOUT=8). A transaction-level
// model tracks who owns the port and checks every output on every negedge;
// per-scenario literal checks pin the model. Build with IOMEM_ARB_TIMEOUT_EN
// defined to exercise the timeout path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iomem_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;
`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*32-1:0]   req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_wstrb;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          req_rdata;
    logic                 t_valid;
    logic                 t_ready;
    logic [31:0]          t_addr;
    logic [31:0]          t_wdata;
    logic [3:0]           t_wstrb;
    logic [31:0]          t_rdata;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    always #5 clk = ~clk;

    iomem_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_ready   (req_ready),
        .req_rdata   (req_rdata),
        .t_valid     (t_valid),
        .t_ready     (t_ready),
        .t_addr      (t_addr),
        .t_wdata     (t_wdata),
        .t_wstrb     (t_wstrb),
        .t_rdata     (t_rdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ---------------- stimulus state ----------------
    int          remaining [NREQ];
    bit          drop      [NREQ];
    logic [31:0] m_addr    [NREQ];
    logic [31:0] m_wdata   [NREQ];
    logic [3:0]  m_wstrb   [NREQ];
    int          tgt_delay;          // cycles of t_valid before t_ready; <0 = never
    logic [31:0] tgt_rdata;
    int          run;

    // ---------------- bookkeeping ----------------
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdy_cnt [NREQ];
    int          gnt_q [$];
    int          tv_rise_cyc, busy_rise_cyc, req_rise_cyc, last_rdy_cyc;
    logic [31:0] last_rdata, last_taddr, last_twdata;
    logic [3:0]  last_twstrb;
    logic        prev_tv, prev_busy;
    logic [NREQ-1:0] prev_req, done;

    // ---------------- transaction-level model ----------------
    // m_last = last master granted; the next search starts just after it.
    bit m_busy;
    int m_gid;
    int m_last;
    int m_wait;
    bit m_err;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_gid  <= 0;
            m_last <= NREQ - 1;
            m_wait <= 0;
            m_err  <= 1'b0;
        end else if (m_busy) begin
            if (!req_valid[m_gid]) begin
                m_busy <= 1'b0;
            end else if (t_ready) begin
                m_busy <= 1'b0;
            end else if (TO_EN && m_wait == TIMEOUT) begin
                m_busy <= 1'b0;
                m_err  <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req_valid[c]) begin
                    m_gid  <= c;
                    m_last <= c;
                    m_busy <= 1'b1;
                    m_wait <= 0;
                    break;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic        e_tv, e_to;
        logic [31:0] e_rdy;
        e_tv  = m_busy && req_valid[m_gid];
        e_to  = TO_EN && e_tv && !t_ready && (m_wait == TIMEOUT);
        e_rdy = (e_tv && (t_ready || e_to)) ? (32'd1 << m_gid) : 32'd0;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("t_valid", 32'(t_valid), 32'(e_tv));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("req_ready", 32'(req_ready), e_rdy);
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        if (e_tv) begin
            chk("t_addr", t_addr, m_addr[m_gid]);
            chk("t_wdata", t_wdata, m_wdata[m_gid]);
            chk("t_wstrb", 32'(t_wstrb), 32'(m_wstrb[m_gid]));
        end
        if (e_rdy != 0) begin
            chk("req_rdata", req_rdata, e_to ? 32'hDEAD_BEEF : t_rdata);
        end
    endtask

    // One clock: check at negedge, masters update at posedge+1, target at +2.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        compare_all();
        if (t_valid && !prev_tv) tv_rise_cyc = cyc;
        if (busy && !prev_busy) begin
            gnt_q.push_back(int'(grant_id));
            busy_rise_cyc = cyc;
        end
        if (req_valid != '0 && prev_req == '0) req_rise_cyc = cyc;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                rdy_cnt[i]++;
                last_rdy_cyc = cyc;
                last_rdata   = req_rdata;
            end
        end
        if (t_valid) begin
            last_taddr  = t_addr;
            last_twdata = t_wdata;
            last_twstrb = t_wstrb;
        end
        prev_tv   = t_valid;
        prev_busy = busy;
        prev_req  = req_valid;
        done      = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (done[i] && remaining[i] > 0) remaining[i]--;
            if (drop[i]) remaining[i] = 0;
            req_valid[i]          = (remaining[i] > 0);
            req_addr[32*i +: 32]  = m_addr[i];
            req_wdata[32*i +: 32] = m_wdata[i];
            req_wstrb[4*i +: 4]   = m_wstrb[i];
        end
        #1;
        if (t_valid) begin
            t_ready = (tgt_delay >= 0) && (run >= tgt_delay);
            run++;
        end else begin
            t_ready = 1'b0;
            run     = 0;
        end
        t_rdata = tgt_rdata;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            drop[i]      = 1'b0;
        end
        tgt_delay = 1;
        cycle();
        cycle();
        resetn = 1'b1;
        cycle();
    endtask

    task automatic run_until_done(input string name, input int budget);
        int pend;
        for (int n = 0; n < budget; n++) begin
            pend = 0;
            for (int i = 0; i < NREQ; i++) pend += remaining[i];
            if (pend == 0) break;
            cycle();
        end
        pend = 0;
        for (int i = 0; i < NREQ; i++) pend += remaining[i];
        chk({name, " completed within budget"}, 32'(pend), 32'd0);
        cycle();
        cycle();
    endtask

    task automatic wait_grant(input string name, input int id);
        for (int n = 0; n < 20 && !(busy && int'(grant_id) == id); n++) cycle();
        chk({name, " grant seen"}, 32'(busy && int'(grant_id) == id), 32'd1);
    endtask

    initial begin
        int r0, r1, q0, abort_cyc;
        req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        t_ready = 1'b0; t_rdata = '0; tgt_rdata = '0; run = 0;
        prev_tv = 1'b0; prev_busy = 1'b0; prev_req = '0; done = '0;
        tv_rise_cyc = 0; busy_rise_cyc = 0; req_rise_cyc = 0; last_rdy_cyc = 0;
        last_rdata = '0; last_taddr = '0; last_twdata = '0; last_twstrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            rdy_cnt[i] = 0; remaining[i] = 0; drop[i] = 1'b0;
            m_addr[i] = 32'h0300_0000 + 32'(4*i); m_wdata[i] = 32'h1000 + 32'(i); m_wstrb[i] = 4'hF;
        end

        // Reset state
        do_reset();
        chk("reset grant_id", 32'(grant_id), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset t_valid", 32'(t_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);
        $display("[TB] reset state checked");

        // Single master write
        do_reset();
        m_addr[0] = 32'h0300_0000; m_wdata[0] = 32'h5; m_wstrb[0] = 4'hF;
        tgt_delay = 1;
        r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
        remaining[0] = 1;
        run_until_done("single", 20);
        chk("single ready0 pulses", 32'(rdy_cnt[0] - r0), 32'd1);
        chk("single ready1 pulses", 32'(rdy_cnt[1] - r1), 32'd0);
        chk("single t_addr", last_taddr, 32'h0300_0000);
        chk("single t_wdata", last_twdata, 32'h5);
        chk("single t_wstrb", 32'(last_twstrb), 32'hF);
        chk("single req->t_valid latency", 32'(tv_rise_cyc - req_rise_cyc), 32'd1);
        chk("single t_valid->ready", 32'(last_rdy_cyc - tv_rise_cyc), 32'd1);
        $display("[TB] single write: addr=0x%08h wdata=0x%08h", last_taddr, last_twdata);

        // Contention: both masters, two transactions each
        do_reset();
        m_addr[1] = 32'h0300_0004; m_wdata[1] = 32'h77; m_wstrb[1] = 4'h3;
        q0 = gnt_q.size();
        remaining[0] = 2; remaining[1] = 2;
        run_until_done("contention", 60);
        chk("contention grant count", 32'(gnt_q.size() - q0), 32'd4);
        if (gnt_q.size() >= q0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("contention grant %0d", k), 32'(gnt_q[q0+k]), 32'(k % 2));
            end
        end
        $display("[TB] contention: %0d grants recorded", gnt_q.size() - q0);

        // Read by master 1
        do_reset();
        m_addr[1] = 32'h0300_0000; m_wstrb[1] = 4'h0;
        tgt_rdata = 32'hA5A5_A5A5;
        r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
        remaining[1] = 1;
        run_until_done("read", 20);
        chk("read ready1 pulses", 32'(rdy_cnt[1] - r1), 32'd1);
        chk("read ready0 pulses", 32'(rdy_cnt[0] - r0), 32'd0);
        chk("read rdata", last_rdata, 32'hA5A5_A5A5);
        $display("[TB] read: rdata=0x%08h", last_rdata);

        // Abort: master 0 withdraws in its third BUSY cycle, master 1 waiting
        do_reset();
        tgt_delay = -1;
        remaining[0] = 1; remaining[1] = 1;
        r0 = rdy_cnt[0];
        wait_grant("abort m0", 0);
        cycle();
        drop[0] = 1'b1;
        cycle();
        drop[0] = 1'b0;
        abort_cyc = cyc + 1;
        chk("abort t_valid falls", 32'(t_valid), 32'd0);
        chk("abort busy same cycle", 32'(busy), 32'd1);
        chk("abort req_ready", 32'(req_ready), 32'd0);
        tgt_delay = 1;
        run_until_done("abort", 20);
        chk("abort next grant", 32'(gnt_q[gnt_q.size()-1]), 32'd1);
        chk("abort idle bubble", 32'(busy_rise_cyc - abort_cyc), 32'd2);
        chk("abort no ready0", 32'(rdy_cnt[0] - r0), 32'd0);
        $display("[TB] abort: m1 granted at cycle %0d", busy_rise_cyc);

        // Reset while BUSY
        do_reset();
        tgt_delay = -1;
        remaining[1] = 1;
        wait_grant("rst-busy m1", 1);
        cycle();
        chk("rst-busy grant before", 32'(grant_id), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst-busy t_valid async", 32'(t_valid), 32'd0);
        chk("rst-busy busy async", 32'(busy), 32'd0);
        chk("rst-busy req_ready async", 32'(req_ready), 32'd0);
        remaining[1] = 0;
        cycle();
        resetn = 1'b1;
        cycle();
        chk("rst-busy grant after", 32'(grant_id), 32'd0);
        $display("[TB] reset mid-busy checked");

`ifdef IOMEM_ARB_TIMEOUT_EN
        // Target never answers: arbiter completes after TIMEOUT cycles
        do_reset();
        tgt_delay = -1;
        m_wstrb[0] = 4'h0;
        r0 = rdy_cnt[0];
        remaining[0] = 1;
        run_until_done("timeout", 40);
        chk("timeout ready0 pulses", 32'(rdy_cnt[0] - r0), 32'd1);
        chk("timeout delay", 32'(last_rdy_cyc - tv_rise_cyc), 32'd8);
        chk("timeout rdata", last_rdata, 32'hDEAD_BEEF);
        chk("timeout_err set", 32'(timeout_err), 32'd1);
        repeat (3) cycle();
        chk("timeout_err sticky", 32'(timeout_err), 32'd1);
        do_reset();
        chk("timeout_err cleared by reset", 32'(timeout_err), 32'd0);
        $display("[TB] timeout: ready %0d cycles after t_valid", last_rdy_cyc - tv_rise_cyc);
`else
        // Without the timeout feature a silent target holds the arbiter BUSY
        do_reset();
        tgt_delay = -1;
        r0 = rdy_cnt[0];
        remaining[0] = 1;
        repeat (20) cycle();
        chk("no-timeout still busy", 32'(busy), 32'd1);
        chk("no-timeout no ready", 32'(rdy_cnt[0] - r0), 32'd0);
        chk("no-timeout err low", 32'(timeout_err), 32'd0);
        drop[0] = 1'b1;
        cycle();
        cycle();
        drop[0] = 1'b0;
        $display("[TB] silent target held BUSY for 20 cycles");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
